// File: rtl/mfm_pkg.sv
// Shared types and constants for the MFM pulse generator.
// Interval codes are half-cell counts; fifo entries carry the code and the end-of-stream tag.
package mfm_pkg;

   localparam int MFM_SHORT = 2;
   localparam int MFM_MED   = 3;
   localparam int MFM_LONG  = 4;
   localparam int MFM_ID    = 5;

   // Stored code width: wide enough for any legal interval up to 7 half-cells.
   localparam int MFM_CODE_W = 3;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic                  last;
      logic [MFM_CODE_W-1:0] code;
   } fifo_entry_t;

   function automatic int interval_clks(input int code, input int cell_clks);
      return code * cell_clks;
   endfunction

endpackage

// File: rtl/mfm_code_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop, flush and an occupancy count.
// Push when full and pop when empty are ignored; flush empties it at the next edge.
module mfm_code_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          push_en, pop_en;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign push_en = push && !full && !flush;
   assign pop_en  = pop && !empty && !flush;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_en && !pop_en)      level_d = level_q + LW'(1);
         else if (pop_en && !push_en) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: storage is left unreset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mfm_pulse_gen.sv
// MFM write pulse generator: queues half-cell interval codes and emits one so pulse
// at the start of each interval, chaining intervals back to back until a last-tagged entry.
module mfm_pulse_gen
   import mfm_pkg::*;
#(
   parameter int CELL_CLKS  = 5,
   parameter int PULSE_CLKS = 2,
   parameter int CODE_W     = 3,
   parameter int DEPTH      = 4,
   parameter int MIN_CODE   = 2,
   parameter int MAX_CODE   = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [CODE_W-1:0]      in_code,
   input  logic                   in_last,
   output logic                   in_ready,
   input  logic                   flush,
   output logic                   so,
   output logic                   busy,
   output logic                   done,
   output logic                   underrun,
   output logic                   err_code,
   output logic [$clog2(DEPTH):0] level
);

   localparam int CNT_W = $clog2(MAX_CODE * CELL_CLKS);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fifo_entry_t     cur_q, cur_d;
   logic            done_q, done_d;
   logic            underrun_q, underrun_d;
   logic            err_q, err_d;

   fifo_entry_t     wr_entry, head;
   logic            offer_ok, code_legal, push, pop;
   logic            fifo_full, fifo_empty;
   logic [CNT_W-1:0] elapsed;

   function automatic logic [CNT_W-1:0] interval_last(input logic [MFM_CODE_W-1:0] code);
      return CNT_W'(interval_clks(int'(code), CELL_CLKS) - 1);
   endfunction

   assign in_ready   = (level != LVL_W'(DEPTH));
   assign offer_ok   = in_valid && in_ready;
   assign code_legal = (int'(in_code) >= MIN_CODE) && (int'(in_code) <= MAX_CODE);
   assign push       = offer_ok && code_legal && !flush;
   assign wr_entry   = '{last: in_last, code: MFM_CODE_W'(in_code)};

   mfm_code_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fifo_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (wr_entry),
      .rdata (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // The pulse covers the first PULSE_CLKS cycles of every interval.
   assign elapsed  = interval_last(cur_q.code) - cnt_q;
   assign so       = (state_q == RUN) && (elapsed < CNT_W'(PULSE_CLKS));
   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign underrun = underrun_q;
   assign err_code = err_q;

   always_comb begin
      // NOTE: every variable is defaulted first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_d      = cur_q;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      err_d      = err_q;
      pop        = 1'b0;

      if (offer_ok && !code_legal) err_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cur_d   = head;
               cnt_d   = interval_last(head.code);
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (cur_q.last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (!fifo_empty) begin
               pop   = 1'b1;
               cur_d = head;
               cnt_d = interval_last(head.code);
            end else begin
               state_d    = IDLE;
               underrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including the end-of-interval decision.
      if (flush) begin
         state_d    = IDLE;
         done_d     = 1'b0;
         underrun_d = 1'b0;
         err_d      = 1'b0;
         pop        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_q      <= '0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_q      <= cur_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_mfm_pulse_gen.sv
// Scoreboard bench for mfm_pulse_gen: the stimulus side predicts pulse start and done
// cycles from the interval rules; a negedge monitor pops and compares as events occur.
module tb_mfm_pulse_gen;

   localparam int CELL_CLKS  = 5;
   localparam int PULSE_CLKS = 2;
   localparam int CODE_W     = 3;
   localparam int DEPTH      = 4;
   localparam int MIN_CODE   = 2;
   localparam int MAX_CODE   = 5;

   logic                   clk = 1'b0;
   logic                   reset, in_valid, in_last, flush;
   logic [CODE_W-1:0]      in_code;
   logic                   in_ready, so, busy, done, underrun, err_code;
   logic [$clog2(DEPTH):0] level;

   mfm_pulse_gen #(
      .CELL_CLKS  (CELL_CLKS),
      .PULSE_CLKS (PULSE_CLKS),
      .CODE_W     (CODE_W),
      .DEPTH      (DEPTH),
      .MIN_CODE   (MIN_CODE),
      .MAX_CODE   (MAX_CODE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_code  (in_code),
      .in_last  (in_last),
      .in_ready (in_ready),
      .flush    (flush),
      .so       (so),
      .busy     (busy),
      .done     (done),
      .underrun (underrun),
      .err_code (err_code),
      .level    (level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard queues and reference-model state.
   int rise_q[$];
   int done_q[$];
   int ent_p[$];
   int ent_s[$];
   int prev_end;
   bit prev_last, have_prev, underrun_exp, err_exp;

   function automatic int model_level(input int c);
      int n = 0;
      foreach (ent_p[i]) if (ent_p[i] < c && c < ent_s[i]) n++;
      return n;
   endfunction

   task automatic model_clear();
      ent_p.delete();
      ent_s.delete();
      rise_q.delete();
      done_q.delete();
      have_prev    = 1'b0;
      prev_last    = 1'b0;
      prev_end     = 0;
      underrun_exp = 1'b0;
      err_exp      = 1'b0;
   endtask

   // An entry pushed in cycle p is poppable from p+1 and so starts no earlier than p+2.
   // It chains with no gap only if it was queued before the previous non-last interval's
   // final cycle; otherwise the generator passes through IDLE first.
   task automatic model_push(input int p, input int code, input bit last);
      int s;
      if (!have_prev) s = p + 2;
      else if (!prev_last && p + 2 <= prev_end) s = prev_end;
      else begin
         if (!prev_last) underrun_exp = 1'b1;
         s = (p + 2 > prev_end + 1) ? p + 2 : prev_end + 1;
      end
      ent_p.push_back(p);
      ent_s.push_back(s);
      rise_q.push_back(s);
      prev_end  = s + code * CELL_CLKS;
      prev_last = last;
      have_prev = 1'b1;
      if (last) done_q.push_back(prev_end);
   endtask

   // Called at a negedge; holds the offer for exactly one cycle.
   task automatic offer(input int code, input bit last);
      int c;
      bit rdy;
      c   = cyc;
      rdy = (model_level(c) != DEPTH);
      check("in_ready", in_ready, rdy);
      check("level", level, model_level(c));
      in_valid = 1'b1;
      in_code  = code[CODE_W-1:0];
      in_last  = last;
      if (rdy) begin
         if (code < MIN_CODE || code > MAX_CODE) err_exp = 1'b1;
         else model_push(c, code, last);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) @(negedge clk);
      check("rst_so", so, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_underrun", underrun, 0);
      check("rst_err", err_code, 0);
      check("rst_level", level, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic drain();
      int lim = 0;
      repeat (3) @(negedge clk);
      while (have_prev && cyc <= prev_end + 1 && lim < 400) begin
         @(negedge clk);
         lim++;
      end
      if (lim >= 400) check("drain_timeout", lim, 0);
      if (have_prev && !prev_last) underrun_exp = 1'b1;
      check("drain_level", level, 0);
      check("drain_busy", busy, 0);
      check("drain_underrun", underrun, underrun_exp);
      check("drain_err", err_code, err_exp);
      check("missing_rises", rise_q.size(), 0);
      check("missing_done", done_q.size(), 0);
   endtask

   // Abort a code-4 interval at its 6th cycle with two more entries queued,
   // using flush or reset; a push offered in the same cycle must be lost.
   task automatic abort_run(input bit use_reset);
      int s;
      do_reset(2);
      offer(4, 0);
      offer(4, 0);
      offer(4, 0);
      offer(7, 0);
      s = ent_s[0];
      while (cyc < s + 5) @(negedge clk);
      check("abort_pre_level", level, model_level(cyc));
      check("abort_pre_busy", busy, 1);
      check("abort_pre_err", err_code, err_exp);
      if (use_reset) reset = 1'b1;
      else flush = 1'b1;
      in_valid = 1'b1;
      in_code  = 3'd3;
      in_last  = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("abort_so", so, 0);
      check("abort_busy", busy, 0);
      check("abort_level", level, 0);
      check("abort_done", done, 0);
      check("abort_underrun", underrun, 0);
      check("abort_err", err_code, 0);
      check("abort_in_ready", in_ready, 1);
      model_clear();
      repeat (60) @(negedge clk);
      check("abort_post_busy", busy, 0);
      check("abort_post_underrun", underrun, 0);
   endtask

   task automatic random_stream(input int n);
      int ill[4] = '{0, 1, 6, 7};
      for (int i = 0; i < n; i++) begin
         int gap, code;
         bit last;
         gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         if ($urandom_range(0, 9) == 0) code = ill[$urandom_range(0, 3)];
         else code = int'($urandom_range(MIN_CODE, MAX_CODE));
         last = ($urandom_range(0, 4) == 0);
         offer(code, last);
      end
   endtask

   // Monitor: compares every so rising edge and done strobe against the queues.
   logic so_prev = 1'b0;
   int   rise_cyc = 0;
   always @(negedge clk) begin
      if (so && !so_prev) begin
         rise_cyc <= cyc;
         check("busy_at_rise", busy, 1);
         if (rise_q.size() == 0) check("unexpected_rise", cyc, -1);
         else check("rise_cycle", cyc, rise_q.pop_front());
      end
      if (!so && so_prev) check("pulse_width", cyc - rise_cyc, PULSE_CLKS);
      if (done) begin
         check("busy_at_done", busy, 0);
         if (done_q.size() == 0) check("unexpected_done", cyc, -1);
         else check("done_cycle", cyc, done_q.pop_front());
      end
      so_prev <= so;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_code  = '0;
      in_last  = 1'b0;
      flush    = 1'b0;
      model_clear();
      @(negedge clk);

      do_reset(3);
      offer(2, 0);
      offer(3, 0);
      offer(4, 1);
      drain();

      do_reset(1);
      offer(2, 0);
      drain();

      do_reset(1);
      offer(1, 0);
      offer(6, 0);
      drain();

      do_reset(1);
      repeat (6) offer(4, 0);
      drain();

      abort_run(1'b0);
      abort_run(1'b1);

      do_reset(1);
      random_stream(150);
      drain();

      do_reset(1);
      random_stream(150);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
